bitwise_slice_sequencer: RTL and testbench



---
 rtl/bitwise_slice_sequencer.sv | 118 +++++++++++
 tb/tb_bitwise_slice_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/bitwise_slice_sequencer.sv
// bitwise_slice_sequencer: runs a WIDTH-bit AND/OR/XOR/NOR through a
// SLICE-bit logic unit, one slice per cycle, low slice first.
module bitwise_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  // Operands must split into whole slices.
  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_cfg
      $error("bitwise_slice_sequencer: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [SLICE-1:0] sa, sb, sres;
  logic [WIDTH-1:0] result_nxt;

  // Narrow logic unit on the current slice, merged into a copy of result.
  always_comb begin
    sa = a_q[int'(idx)*SLICE +: SLICE];
    sb = b_q[int'(idx)*SLICE +: SLICE];
    case (op_q)
      2'b00:   sres = sa & sb;
      2'b01:   sres = sa | sb;
      2'b10:   sres = sa ^ sb;
      default: sres = ~(sa | sb);
    endcase
    result_nxt = result;
    result_nxt[int'(idx)*SLICE +: SLICE] = sres;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, slice counter and result assembly; zero is updated
  // only when the final slice lands so it stays valid until then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            result <= '0;
            idx    <= '0;
          end
        end
        S_RUN: begin
          result <= result_nxt;
          if (idx == LAST) begin
            zero <= (result_nxt == '0);
            idx  <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_slice_sequencer.sv
// Directed bench for bitwise_slice_sequencer (32/8 and 16/16 instances).
module tb_bitwise_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero;
  logic [31:0] result;

  logic        start1;
  logic [1:0]  op1;
  logic [15:0] a1, b1;
  logic        busy1, done1, zero1;
  logic [15:0] result1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  bitwise_slice_sequencer #(.WIDTH(32), .SLICE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  bitwise_slice_sequencer #(.WIDTH(16), .SLICE(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(result1), .zero(zero1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept an op and follow it through RUN, DONE and the following IDLE cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_r, input logic exp_z);
    start = 1'b1; op = o; a = va; b = vb;
    step();
    start = 1'b0; a = '0; b = '0; op = 2'b00;
    check({tag, "_clr"}, result, 32'h0);
    for (int k = 0; k < 6; k++) begin
      check({tag, "_busy"}, {31'b0, busy}, {31'b0, k < 5});
      check({tag, "_done"}, {31'b0, done}, {31'b0, k == 4});
      if (k == 4) begin
        check({tag, "_res"}, result, exp_r);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
      end
      if (k < 5) step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_res", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    step();

    // Test 1: OR
    run_op("or", 2'b01, 32'hF0F00000, 32'h0F0F00FF, 32'hFFFF00FF, 1'b0);
    // Test 2: AND, NOR, XOR
    run_op("and", 2'b00, 32'hFFFF0000, 32'h00FFFF00, 32'h00FF0000, 1'b0);
    run_op("nor", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_op("xor", 2'b10, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1);

    // Test 3: start while busy is ignored, operands already captured
    start = 1'b1; op = 2'b01; a = 32'h1; b = 32'h2;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 32'hFFFFFFFF;
    step();
    start = 1'b0;
    step(); step();
    check("ign_done", {31'b0, done}, 32'h1);
    check("ign_res", result, 32'h00000003);
    start = 1'b1; a = 32'hFFFFFFFF;
    step();
    start = 1'b0; a = '0; b = '0;
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (busy || done) seen_done = 1'b1;
      step();
    end
    check("ign_noreaccept", {31'b0, seen_done}, 32'h0);
    check("ign_hold", result, 32'h00000003);

    // Test 4: reset mid-operation (zero=1 is not left from the previous op; force it)
    run_op("nor2", 2'b11, 32'h0, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFFF; b = 32'h0;
    step();
    start = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_res", result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'h0);
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    check("abort_nodone", {31'b0, seen_done}, 32'h0);
    run_op("post", 2'b01, 32'hA, 32'h5, 32'h0000000F, 1'b0);

    // Test 5: start held high -> back-to-back ops every 6 cycles
    start = 1'b1; op = 2'b10; a = 32'hDEADBEEF; b = 32'h0F0F0F0F;
    step();
    for (int k = 0; k < 18; k++) begin
      check("hold_done", {31'b0, done}, {31'b0, (k % 6) == 4});
      check("hold_busy", {31'b0, busy}, {31'b0, (k % 6) != 5});
      if ((k % 6) >= 4) check("hold_res", result, 32'hD1A2B1E0);
      step();
    end
    start = 1'b0;
    step(); step(); step(); step(); step(); step();

    // Test 6: NSLICE=1 instance
    start1 = 1'b1; op1 = 2'b00; a1 = 16'hFF0F; b1 = 16'h0FFF;
    step();
    start1 = 1'b0; a1 = '0; b1 = '0;
    check("n1_busy0", {31'b0, busy1}, 32'h1);
    check("n1_done0", {31'b0, done1}, 32'h0);
    step();
    check("n1_done", {31'b0, done1}, 32'h1);
    check("n1_res", {16'b0, result1}, 32'h00000F0F);
    check("n1_zero", {31'b0, zero1}, 32'h0);
    step();
    check("n1_idle", {31'b0, busy1}, 32'h0);
    check("n1_hold", {16'b0, result1}, 32'h00000F0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
